// File: rtl/ram_64bit_store_if.sv
// ram_64bit_store_if: store request bus of the 64-bit data RAM.
// Signals: wr_valid/wr_ready request handshake; address/size/wr_data the store;
// done completion pulse, busy split-in-progress, err misaligned-reject pulse.
interface ram_64bit_store_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  address;
  logic [1:0]  size;
  logic [63:0] wr_data;
  logic        done;
  logic        busy;
  logic        err;
  modport master(output wr_valid, address, size, wr_data, input wr_ready, done, busy, err);
  modport slave(input wr_valid, address, size, wr_data, output wr_ready, done, busy, err);
endinterface

// File: rtl/ram_64bit_store.sv
// ram_64bit_store: byte-addressed 256-byte RAM (32 x 64-bit lines) with 1/2/4/8-byte stores.
// Ports: clock, reset (async, active-high); bus (slave store handshake, see interface);
// rd_line/rd_data synchronous read-before-write line read port.
// Optional macro STORE_ALIGN_CHECK_EN: misaligned stores are dropped and pulse err.
module ram_64bit_store #(
  parameter int          LINES      = 32,
  parameter logic [63:0] INIT_VALUE = 64'h0
) (
  input  logic              clock,
  input  logic              reset,
  ram_64bit_store_if.slave  bus,
  input  logic [4:0]        rd_line,
  output logic [63:0]       rd_data
);
  typedef enum logic {IDLE, SECOND} state_t;
  state_t       r_state, w_next;
  logic [63:0]  r_mem [LINES];
  logic [63:0]  r_rd_data, r_rem_data;
  logic [7:0]   r_rem_be;
  logic [4:0]   r_rem_line;
  logic         r_done;
  logic [3:0]   w_nbytes;
  logic [15:0]  w_mask;
  logic [127:0] w_data;
  logic         w_hs, w_split, w_mis, w_first;
  logic [4:0]   w_we_line;
  logic [7:0]   w_we_be;
  logic [63:0]  w_we_data;
  // The store is laid out over a two-line window: the low half targets the
  // addressed line, the high half spills into the next line.
  always_comb begin
    w_nbytes  = 4'd1 << bus.size;
    w_mask    = ((16'd1 << w_nbytes) - 16'd1) << bus.address[2:0];
    w_data    = {64'd0, bus.wr_data} << {bus.address[2:0], 3'b000};
    w_hs      = bus.wr_valid && r_state == IDLE;
    w_split   = |w_mask[15:8];
`ifdef STORE_ALIGN_CHECK_EN
    w_mis     = |(bus.address[2:0] & (w_nbytes[2:0] - 3'd1));
`else
    w_mis     = 1'b0;
`endif
    w_first   = w_hs && !w_mis;
    w_next    = (w_first && w_split) ? SECOND : IDLE;
    w_we_line = r_state == SECOND ? r_rem_line : bus.address[7:3];
    w_we_be   = r_state == SECOND ? r_rem_be : (w_first ? w_mask[7:0] : 8'h00);
    w_we_data = r_state == SECOND ? r_rem_data : w_data[63:0];
    bus.wr_ready = r_state == IDLE;
    bus.busy     = r_state == SECOND;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LINES; i++) r_mem[i] <= INIT_VALUE;
      r_rd_data  <= '0;
      r_rem_data <= '0;
      r_rem_be   <= '0;
      r_rem_line <= '0;
      r_done     <= 1'b0;
    end else begin
      for (int j = 0; j < 8; j++)
        if (w_we_be[j]) r_mem[w_we_line][8*j +: 8] <= w_we_data[8*j +: 8];
      r_rd_data <= r_mem[rd_line];
      r_done    <= (w_first && !w_split) || r_state == SECOND;
      if (w_first && w_split) begin
        r_rem_data <= w_data[127:64];
        r_rem_be   <= w_mask[15:8];
        r_rem_line <= bus.address[7:3] + 5'd1;
      end
    end
  end
`ifdef STORE_ALIGN_CHECK_EN
  logic r_err;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_err <= 1'b0;
    else r_err <= w_hs && w_mis;
  end
  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif
  assign bus.done = r_done;
  assign rd_data  = r_rd_data;
endmodule

// File: doc/ram_64bit_store.md
Name: ram_64bit_store

Overview:
- Byte-addressed 256-byte data RAM organised as 32 lines of 64 bits, little-endian; the write-side counterpart of the 64-bit ROM read path.
- Accepts store requests of 1/2/4/8 bytes at any byte address through a valid/ready handshake.
- Stores that cross a 64-bit line boundary are split into two line writes by an internal FSM.
- A synchronous line-read port lets the rest of the design, and the bench, inspect contents.

Parameters:
- LINES, 32, number of 64-bit lines; fixed at 32 for the 8-bit address.
- INIT_VALUE, 64'h0, value every line takes on reset.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr_valid  input  1  store request valid.
- wr_ready  output  1  block can accept a request this cycle.
- address  input  8  byte address of the least significant byte stored.
- size  input  2  store width: 00=1 byte, 01=2 bytes, 10=4 bytes, 11=8 bytes.
- wr_data  input  64  store data, right-justified; only the low 8<<size bits are used.
- done  output  1  one-cycle pulse when a store has fully completed.
- busy  output  1  high while a split store's second half is pending.
- rd_line  input  5  line index for the read port.
- rd_data  output  64  contents of line rd_line, registered one cycle.
- err  output  1  misaligned-reject pulse; only present with the optional feature, otherwise tied 0.

Behaviour:
- Reset (async, active-high) values:
  - All lines = INIT_VALUE; FSM = IDLE.
  - wr_ready=1, done=0, busy=0, err=0, rd_data=0.
- Definitions:
  - nbytes = 1<<size; off = address[2:0]; line = address[7:3].
  - Byte k of wr_data (k < nbytes) goes to byte address (address+k) mod 256.
  - Byte j of a line occupies bits [8j+7:8j].
- IDLE:
  - wr_ready=1. A handshake occurs when wr_valid && wr_ready.
  - On the handshake edge, bytes off..min(7, off+nbytes-1) of line are written; all other bytes are unchanged (byte enables, no read-modify-write).
  - If off+nbytes <= 8 (no split): next cycle done=1; stay in IDLE.
  - If off+nbytes > 8 (split): latch the remaining nbytes-(8-off) bytes and the target line (line+1) mod 32; go to SECOND.
- SECOND:
  - wr_ready=0, busy=1.
  - On the next edge, the remaining bytes are written to bytes 0.. of the next line; return to IDLE; done=1 in the following cycle.
- Latency:
  - Non-split store: 1 cycle, done the cycle after the handshake.
  - Split store: 2 cycles; throughput is one request per cycle when requests do not split.
- Wrap-around: a store at address 8'hFC of size 11 writes bytes 4..7 of line 31 and bytes 0..3 of line 0.
- wr_valid held high during SECOND is ignored and not accepted until wr_ready returns to 1; the requester must hold its request stable.
- Read port:
  - rd_data <= line[rd_line] each edge.
  - If the same edge writes that line, rd_data returns the old (pre-write) value; this is read-before-write.
- Reset asserted during SECOND: the pending half is discarded, all lines revert to INIT_VALUE, no done pulse is produced.
- size and address are sampled only at the handshake; later changes have no effect on an in-flight store.

Optional Feature:
- Macro STORE_ALIGN_CHECK_EN.
- Defined:
  - A request with address not a multiple of nbytes is accepted (handshake completes) but writes nothing.
  - err pulses 1 in the cycle after the handshake; done stays 0; SECOND is never entered.
- Undefined:
  - err is tied 0; misaligned stores are split as described in Behaviour.

Test Plan:
- Reset, then a store of size 11 at address 8'h08 with data 64'h1122334455667788 -> after 1 cycle done=1; rd_line=1 returns 64'h1122334455667788; line 0 remains 0.
- 8 byte stores (size 00) at addresses 8'h00..8'h07 with data 8'hA0+k -> line 0 = 64'hA7A6A5A4A3A2A1A0; one done pulse per store; wr_ready stays 1 throughout.
- Split store of size 10 at address 8'h36 with data 32'hDEADBEEF -> busy=1 for one cycle; line 6 bytes 6,7 = EF,BE; line 7 bytes 0,1 = AD,DE; done 2 cycles after the handshake.
- Wrap-around store of size 11 at address 8'hFD with data 64'h0807060504030201 -> line 31 bytes 5..7 = 01,02,03; line 0 bytes 0..4 = 04..08.
- Reset asserted during SECOND of a split store -> no done pulse; all lines read 0; wr_ready=1 immediately.
- With STORE_ALIGN_CHECK_EN defined, a store of size 01 at address 8'h03 -> err=1 for one cycle, done=0, memory unchanged. Without the macro, the same store writes byte 3 of line 0 and byte 4 of line 0 with no split.
